// File: rtl/countdown_timer.sv
// Loadable down-counting timer with prescaler, one-shot/auto-reload modes,
// a registered one-cycle expiry pulse and a saturating expiry counter.
module countdown_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  expired,
  output logic [WIDTH-1:0]      expire_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [WIDTH-1:0]      ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0]      CNT_MAX = '1;
  localparam logic [PRESCALE_W-1:0] PSC_ONE = PRESCALE_W'(1);

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        count_q, count_d;
  logic [WIDTH-1:0]        reload_q, reload_d;
  logic [WIDTH-1:0]        expire_cnt_q, expire_cnt_d;
  logic [PRESCALE_W-1:0]   psc_q, psc_d;
  logic                    expired_q, expired_d;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    reload_d     = reload_q;
    expire_cnt_d = expire_cnt_q;
    psc_d        = psc_q;
    expired_d    = 1'b0;

    if (load) begin
      count_d      = load_value;
      reload_d     = load_value;
      expire_cnt_d = '0;
      psc_d        = '0;
      state_d      = IDLE;
    end else if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (start && state_q == IDLE) begin
      // A zero count has nothing to time, so start is dropped.
      if (count_q != '0) begin
        state_d = RUN;
        psc_d   = '0;
      end
    end else if (state_q == RUN) begin
      if (psc_q == prescale) begin
        psc_d = '0;
        if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else if (count_q == ONE) begin
          expired_d = 1'b1;
          if (expire_cnt_q != CNT_MAX) expire_cnt_d = expire_cnt_q + ONE;
          if (auto_reload && reload_q != '0) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = IDLE;
          end
        end
      end else begin
        // Wraps naturally if prescale was lowered below the current phase.
        psc_d = psc_q + PSC_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      reload_q     <= '0;
      expire_cnt_q <= '0;
      psc_q        <= '0;
      expired_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      reload_q     <= reload_d;
      expire_cnt_q <= expire_cnt_d;
      psc_q        <= psc_d;
      expired_q    <= expired_d;
    end
  end

  assign count      = count_q;
  assign busy       = (state_q == RUN);
  assign expired    = expired_q;
  assign expire_cnt = expire_cnt_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: vector table, hand-written corner
// sequences, and randomized stimulus against a behavioural model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load, start, stop, auto_reload;
  logic [7:0] load_value;
  logic [3:0] prescale;
  logic [7:0] count, expire_cnt;
  logic       busy, expired;

  logic       ld2, st2, sp2, ar2;
  logic [1:0] lv2;
  logic [3:0] ps2;
  logic [1:0] cnt2, ecnt2;
  logic       busy2, exp2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk), .rst(rst), .load(load), .load_value(load_value),
    .start(start), .stop(stop), .auto_reload(auto_reload), .prescale(prescale),
    .count(count), .busy(busy), .expired(expired), .expire_cnt(expire_cnt)
  );

  countdown_timer #(.WIDTH(2), .PRESCALE_W(4)) dut2 (
    .clk(clk), .rst(rst), .load(ld2), .load_value(lv2),
    .start(st2), .stop(sp2), .auto_reload(ar2), .prescale(ps2),
    .count(cnt2), .busy(busy2), .expired(exp2), .expire_cnt(ecnt2)
  );

  typedef struct {
    logic       ld;
    logic [7:0] lv;
    logic       st, sp, ar;
    logic [3:0] ps;
    int         e_cnt;
    int         e_busy;
    int         e_exp;
    int         e_ecnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ld, logic [7:0] lv, logic st, logic sp,
                              int e_cnt, int e_busy, int e_exp, int e_ecnt);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.ar = 1'b0; v.ps = 4'd0;
    v.e_cnt = e_cnt; v.e_busy = e_busy; v.e_exp = e_exp; v.e_ecnt = e_ecnt;
    return v;
  endfunction

  task automatic chk(string name, int act, int exp_v);
    nvec++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic drive(logic ld, logic [7:0] lv, logic st, logic sp, logic ar, logic [3:0] ps);
    load = ld; load_value = lv; start = st; stop = sp; auto_reload = ar; prescale = ps;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, int c, int b, int e, int ec);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".busy"}, int'(busy), b);
    chk({tag, ".expired"}, int'(expired), e);
    chk({tag, ".expire_cnt"}, int'(expire_cnt), ec);
  endtask

  // Behavioural reference: timer expressed as plain integer bookkeeping.
  int  m_cnt, m_rel, m_phase, m_ecnt;
  bit  m_run, m_exp;

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_phase = 0; m_ecnt = 0; m_run = 0; m_exp = 0;
  endtask

  task automatic model_step(bit ld, int lv, bit st, bit sp, bit ar, int ps);
    m_exp = 0;
    if (ld) begin
      m_cnt = lv; m_rel = lv; m_ecnt = 0; m_phase = 0; m_run = 0;
    end else if (sp) begin
      m_run = 0;
    end else if (st && !m_run) begin
      if (m_cnt != 0) begin m_run = 1; m_phase = 0; end
    end else if (m_run) begin
      if (m_phase == ps) begin
        m_phase = 0;
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else if (m_cnt == 1) begin
          m_exp = 1;
          m_ecnt = (m_ecnt < 255) ? m_ecnt + 1 : 255;
          if (ar && m_rel != 0) m_cnt = m_rel;
          else begin m_cnt = 0; m_run = 0; end
        end
      end else begin
        m_phase = (m_phase + 1) % 16;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    ld2 = 0; lv2 = 0; st2 = 0; sp2 = 0; ar2 = 0; ps2 = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // One-shot, ignored zero-count start, pause/resume, load+start priority
    tbl.push_back(mk(1, 3, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 10, 0, 0, 10, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 10, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 9, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 8, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 5, 0, 0, 0));
    tbl.push_back(mk(1, 20, 1, 0, 20, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 20, 0, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].ar, tbl[i].ps);
      step();
      chk_all($sformatf("tbl[%0d]", i), tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_exp, tbl[i].e_ecnt);
    end

    // Auto-reload: load 4, prescale 0, 20 cycles after the start edge
    drive(1, 4, 0, 0, 1, 0); step();
    drive(0, 0, 1, 0, 1, 0); step();
    chk_all("ar.k0", 4, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 20; k++) begin
      step();
      chk_all($sformatf("ar.k%0d", k), 4 - (k % 4), 1, (k % 4 == 0) ? 1 : 0, k / 4);
    end

    // Prescale 3, load 2: expiry 8 cycles after the start edge
    drive(1, 2, 0, 0, 0, 3); step();
    drive(0, 0, 1, 0, 0, 3); step();
    drive(0, 0, 0, 0, 0, 3);
    for (int k = 1; k <= 9; k++) begin
      step();
      chk_all($sformatf("psc.k%0d", k), (k < 4) ? 2 : (k < 8) ? 1 : 0,
              (k < 8) ? 1 : 0, (k == 8) ? 1 : 0, (k >= 8) ? 1 : 0);
    end

    // Reset asserted mid-run with count=5
    drive(1, 5, 0, 0, 0, 1); step();
    drive(0, 0, 1, 0, 0, 1); step();
    chk_all("rstrun.pre", 5, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 1);
    #2 rst = 1'b1;
    #1 chk_all("rstrun.async", 0, 0, 0, 0);
    #1 rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0); step();
    chk_all("rstrun.start0", 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0); step();
    chk_all("rstrun.idle", 0, 0, 0, 0);

    // Saturation on the 2-bit instance
    ld2 = 1; lv2 = 2'd1; ar2 = 1; step();
    ld2 = 0; st2 = 1; step();
    chk("sat.start_cnt", int'(cnt2), 1);
    st2 = 0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("sat.exp%0d", k), int'(exp2), 1);
      chk($sformatf("sat.ecnt%0d", k), int'(ecnt2), (k < 3) ? k : 3);
      chk($sformatf("sat.busy%0d", k), int'(busy2), 1);
    end

    // Randomized run against the reference model
    rst = 1'b1; #2; rst = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit ld, st, sp, ar;
      int lv, ps;
      ld = ($urandom_range(99) < 4);
      st = ($urandom_range(99) < 25);
      sp = ($urandom_range(99) < 4);
      ar = ($urandom_range(99) < 60);
      lv = ($urandom_range(9) == 0) ? 0 : $urandom_range(12, 1);
      ps = ($urandom_range(15) == 0) ? $urandom_range(15) : $urandom_range(2);
      drive(ld, 8'(lv), st, sp, ar, 4'(ps));
      model_step(ld, lv, st, sp, ar, ps);
      step();
      chk_all($sformatf("rnd[%0d]", i), m_cnt, int'(m_run), int'(m_exp), m_ecnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
Loadable down-counting timer with a prescaler, one-shot or auto-reload mode, and a one-cycle expiry pulse. It complements the free-running up counter: software or an FSM loads a value, starts it, and receives `expired` when the count reaches zero. It is intended as a timeout and periodic-tick source for later cocotb exercise blocks.

Parameters:
WIDTH, 8, width of the count, load value and expiry counter
PRESCALE_W, 4, width of the prescale divider setting

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  asynchronous, active-high reset
load  input  1  single-cycle request to load load_value
load_value  input  WIDTH  value captured on load
start  input  1  begin or resume counting
stop  input  1  pause counting; count is held
auto_reload  input  1  sampled at expiry: 1 means reload and keep running
prescale  input  PRESCALE_W  divider; one decrement every prescale+1 cycles in RUN
count  output  WIDTH  current count value
busy  output  1  high while in RUN
expired  output  1  one-cycle pulse when the timer reaches terminal count
expire_cnt  output  WIDTH  saturating count of expiries since the last load

Behaviour:
- Reset (async, rst=1):
  - count=0, expire_cnt=0, expired=0, busy=0.
  - Internal reload register is 0, prescale counter is 0, state is IDLE.
- States:
  - IDLE (busy=0).
  - RUN (busy=1). busy is decoded directly from the registered state.
- Command priority within a cycle: load > stop > start.
- load (any state):
  - count and reload register take load_value.
  - expire_cnt is cleared and the prescale counter is cleared.
  - Next state is IDLE; stop and start in the same cycle are ignored.
- stop:
  - In RUN: go to IDLE; count and the prescale counter are held.
  - In IDLE: no effect.
- start in IDLE:
  - If count != 0: go to RUN and clear the prescale counter.
  - If count == 0: ignored; no expiry is generated.
- start in RUN: ignored.
- RUN tick generation:
  - The prescale counter increments each cycle.
  - When it equals prescale, a tick occurs and the counter returns to 0.
  - With prescale=0, every cycle is a tick.
  - The first tick occurs prescale+1 cycles after entering RUN.
- On a tick with count > 1: count decrements by 1.
- On a tick with count == 1 (terminal):
  - expired=1 on the next cycle, for exactly one cycle. It is registered and aligned with count's new value.
  - expire_cnt increments, saturating at 2^WIDTH-1.
  - If auto_reload=1 and the reload register != 0: count takes the reload register value and the state stays RUN.
  - Otherwise: count=0 and the state goes to IDLE.
- Latency from load to the first expiry, with load_value N and start asserted in the cycle after load: N*(prescale+1) cycles after the start edge.
- Changing prescale mid-run takes effect on the next comparison. If the counter is already above the new value, it continues to wrap at 2^PRESCALE_W and then compares normally.
- No wrap-around below 0: count never underflows.
- Reset asserted mid-run forces the reset values immediately, asynchronously. Operation resumes only through a new load.

Test Plan:
- Reset then idle:
  - Stimulus: assert rst mid-run with count=5.
  - Required response: count=0, busy=0, expired=0 immediately; start with count=0 produces no expiry.
- One-shot:
  - Stimulus: load 3, prescale=0, start.
  - Required response: count reads 3,2,1,0 on consecutive cycles; expired high only in the cycle count=0; busy drops in that same cycle; expire_cnt=1.
- Prescale:
  - Stimulus: load 2, prescale=3, start.
  - Required response: count decrements every 4 cycles; expired fires 8 cycles after the start edge.
- Auto-reload:
  - Stimulus: load 4, auto_reload=1, prescale=0, run 20 cycles.
  - Required response: expired pulses every 4 cycles (5 pulses); count sequence 4,3,2,1,4,...; busy stays 1.
- Pause/resume and priority:
  - Stimulus: load 10, start, stop after count=7, idle 5 cycles, start again.
    - Required response: count holds 7 while stopped, then resumes to 6.
  - Stimulus: load asserted with start in the same cycle.
    - Required response: stays IDLE with the new value.
- Saturation:
  - Stimulus: WIDTH=2, load 1, auto_reload=1, run.
  - Required response: expire_cnt stops at 3; the pulses continue.
